s_box_layer_enc_serial: RTL and testbench

Area-optimised forward (encryption) BORON S-box layer that substitutes a 64-bit state using a single 4-bit S-box instance over 16 clock cycles. It is the encryption-direction counterpart of the parallel decryption S-box layer. It sits in the serial/low-area encryption datapath between add-round-key and the permutation stage. Input and output use independent valid/ready handshakes.

---
 rtl/s_box_layer_enc_serial_if.sv | 20 ++
 rtl/s_box_layer_enc_serial.sv | 108 ++++++++++
 tb/tb_s_box_layer_enc_serial.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/s_box_layer_enc_serial_if.sv
// Handshake bundle for the serial forward S-box layer.
// Both sides use valid/ready: a word moves on a rising edge where valid && ready.
interface s_box_layer_enc_serial_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] plainIn;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sBoxLayerOut;

  modport master (
    output in_valid, plainIn, out_ready,
    input  in_ready, out_valid, sBoxLayerOut
  );

  modport slave (
    input  in_valid, plainIn, out_ready,
    output in_ready, out_valid, sBoxLayerOut
  );
endinterface

// File: rtl/s_box_layer_enc_serial.sv
// Serial BORON forward S-box layer: one 4-bit S-box rotated across the 64-bit
// state over 16 cycles; the result is latched into a stable output register.

module s_box_enc (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  always_comb begin
    nib_o = 4'h0;
    case (nib_i)
      4'h0: nib_o = 4'hE;
      4'h1: nib_o = 4'h4;
      4'h2: nib_o = 4'hB;
      4'h3: nib_o = 4'h1;
      4'h4: nib_o = 4'h7;
      4'h5: nib_o = 4'h9;
      4'h6: nib_o = 4'hC;
      4'h7: nib_o = 4'hA;
      4'h8: nib_o = 4'hD;
      4'h9: nib_o = 4'h2;
      4'hA: nib_o = 4'h0;
      4'hB: nib_o = 4'hF;
      4'hC: nib_o = 4'h8;
      4'hD: nib_o = 4'h5;
      4'hE: nib_o = 4'h3;
      4'hF: nib_o = 4'h6;
      default: nib_o = 4'h0;
    endcase
  end
endmodule

module s_box_layer_enc_serial (
  input  logic                          clk,
  input  logic                          rst_n,
  s_box_layer_enc_serial_if.slave       bus,
  output logic [1:0]                    dbg_state
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] data_q, data_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] out_q, out_d;
  logic [3:0]  sub_nib;
  logic [63:0] rot_data;

  s_box_enc u_sbox (
    .nib_i (data_q[3:0]),
    .nib_o (sub_nib)
  );

  // Substituted low nibble enters at the top; after 16 steps all nibbles are home.
  assign rot_data = {sub_nib, data_q[63:4]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 64'h0;
      cnt_q   <= 4'h0;
      out_q   <= 64'h0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.plainIn;
          cnt_d   = 4'h0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        data_d = rot_data;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // Output register only ever sees the finished word.
          out_d   = rot_data;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.sBoxLayerOut = out_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_s_box_layer_enc_serial.sv
// Directed and random bench for the serial forward S-box layer.
`timescale 1ns/1ps
module tb_s_box_layer_enc_serial;
  logic        clk;
  logic        rst_n;
  logic [1:0]  dbg_state;
  int          checks;
  int          failures;
  logic [63:0] exp_q[$];

  s_box_layer_enc_serial_if bus();

  s_box_layer_enc_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: parallel forward layer from its own table
  function automatic logic [3:0] ref_sbox(input logic [3:0] n);
    logic [63:0] tbl;
    tbl = 64'h6358F02DAC971B4E; // S(F)..S(0), nibble i holds S(i)
    return tbl[n*4 +: 4];
  endfunction

  function automatic logic [63:0] ref_layer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = ref_sbox(x[i*4 +: 4]);
    return r;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] w);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.plainIn  = w;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      failures++;
      $display("FAIL send_wait: in_ready=%0b required 1 within 200 cycles", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    bus.plainIn  = {$urandom(), $urandom()};
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plainIn   = 64'h0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %0b required 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %0b required 0", bus.out_valid);
    end
    checks++;
    if (bus.sBoxLayerOut !== 64'h0) begin
      failures++; $display("FAIL reset_out: got %h required 0", bus.sBoxLayerOut);
    end
  endtask

  task automatic test_vector(input logic [63:0] w, input logic [63:0] exp, input string nm);
    int lat;
    bus.out_ready = 1'b1;
    send(w);
    wait_out(lat);
    checks++;
    if (lat != 16) begin
      failures++; $display("FAIL %s_latency: got %0d required 16", nm, lat);
    end
    checks++;
    if (bus.sBoxLayerOut !== exp) begin
      failures++; $display("FAIL %s_data: got %h required %h", nm, bus.sBoxLayerOut, exp);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_handshake: out_valid=%0b in_ready=%0b required 0/1", nm, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    send(64'hFFFFFFFFFFFFFFFF);
    wait_out(lat);
    checks++;
    if (lat != 16) begin
      failures++; $display("FAIL bp_latency: got %0d required 16", lat);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sBoxLayerOut !== 64'h6666666666666666) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%0b in_ready=%0b out=%h required 1/0/6666666666666666",
                 i, bus.out_valid, bus.in_ready, bus.sBoxLayerOut);
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_busy_immunity();
    int lat;
    bus.out_ready = 1'b1;
    send(64'h0123456789ABCDEF);
    bus.in_valid = 1'b1;
    bus.plainIn  = 64'hFFFFFFFFFFFFFFFF;
    wait_out(lat);
    checks++;
    if (lat != 16 || bus.sBoxLayerOut !== 64'hE4B179CAD20F8536) begin
      failures++;
      $display("FAIL busy_first: lat=%0d out=%h required 16/e4b179cad20f8536", lat, bus.sBoxLayerOut);
    end
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL busy_idle: in_ready=%0b required 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    wait_out(lat);
    checks++;
    if (lat != 16 || bus.sBoxLayerOut !== 64'h6666666666666666) begin
      failures++;
      $display("FAIL busy_second: lat=%0d out=%h required 16/6666666666666666", lat, bus.sBoxLayerOut);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send(64'h0123456789ABCDEF);
    repeat (6) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sBoxLayerOut !== 64'h0) begin
      failures++;
      $display("FAIL rst_mid: out_valid=%0b in_ready=%0b out=%h required 0/1/0",
               bus.out_valid, bus.in_ready, bus.sBoxLayerOut);
    end
    repeat (20) step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_discard: out_valid=%0b required 0", bus.out_valid);
    end
    test_vector(64'hFEDCBA9876543210, 64'h6358F02DAC971B4E, "rst_fresh");
  endtask

  task automatic test_random();
    int lat;
    int stall;
    logic [63:0] w;
    logic [63:0] exp;
    for (int k = 0; k < 1000; k++) begin
      w = {$urandom(), $urandom()};
      exp_q.push_back(ref_layer(w));
      bus.out_ready = 1'($urandom_range(0, 1));
      send(w);
      wait_out(lat);
      checks++;
      if (lat != 16) begin
        failures++; $display("FAIL rand_latency[%0d]: got %0d required 16", k, lat);
      end
      if (!bus.out_ready) begin
        stall = $urandom_range(0, 4);
        for (int s = 0; s < stall; s++) step();
        checks++;
        if (bus.out_valid !== 1'b1) begin
          failures++; $display("FAIL rand_hold[%0d]: out_valid=%0b required 1", k, bus.out_valid);
        end
        bus.out_ready = 1'b1;
      end
      exp = exp_q.pop_front();
      checks++;
      if (bus.sBoxLayerOut !== exp) begin
        failures++; $display("FAIL rand_data[%0d]: got %h required %h", k, bus.sBoxLayerOut, exp);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL rand_dup[%0d]: out_valid=%0b in_ready=%0b required 0/1", k, bus.out_valid, bus.in_ready);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL rand_queue: %0d left required 0", exp_q.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plainIn   = 64'h0;
    test_reset();
    test_vector(64'h0000000000000000, 64'hEEEEEEEEEEEEEEEE, "zero");
    test_vector(64'h0123456789ABCDEF, 64'hE4B179CAD20F8536, "ramp");
    test_backpressure();
    test_busy_immunity();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
